// File: rtl/ascii_pkg.sv
// Shared constants and types for the ASCII text writer: control codes,
// printable range, writer FSM states and cursor operations.
package ascii_pkg;

    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_BS    = 8'h08;
    localparam logic [7:0] ASCII_FF    = 8'h0C;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] PRINT_MIN   = 8'h20;
    localparam logic [7:0] PRINT_MAX   = 8'h7E;

    typedef enum logic {
        IDLE,
        CLEAR
    } writer_state_t;

    typedef enum logic [2:0] {
        CUR_NONE,
        CUR_ADVANCE,
        CUR_NEWLINE,
        CUR_RETURN,
        CUR_BACK,
        CUR_HOME
    } cursor_op_t;

endpackage

// File: rtl/text_cursor.sv
// Text cursor position register: advance, newline, carriage return,
// backspace and home, wrapping at the right edge and the bottom row.
module text_cursor
    import ascii_pkg::*;
#(
    parameter int unsigned COLS = 80,
    parameter int unsigned ROWS = 30
) (
    input  logic       clk,
    input  logic       reset_n,
    input  cursor_op_t op,
    output logic [6:0] col,
    output logic [4:0] row
);

    localparam logic [6:0] COL_LAST = 7'(COLS - 1);
    localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);

    logic [6:0] col_q, col_d;
    logic [4:0] row_q, row_d;
    logic [4:0] row_next;

    // No scrolling: moving past the bottom row returns to the top.
    assign row_next = (row_q == ROW_LAST) ? '0 : row_q + 5'd1;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        case (op)
            CUR_ADVANCE: begin
                if (col_q == COL_LAST) begin
                    col_d = '0;
                    row_d = row_next;
                end else begin
                    col_d = col_q + 7'd1;
                end
            end
            CUR_NEWLINE: begin
                col_d = '0;
                row_d = row_next;
            end
            CUR_RETURN: col_d = '0;
            CUR_BACK: begin
                if (col_q != '0) begin
                    col_d = col_q - 7'd1;
                end
            end
            CUR_HOME: begin
                col_d = '0;
                row_d = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col = col_q;
    assign row = row_q;

endmodule

// File: rtl/ascii_text_writer.sv
// Turns the ASCII byte stream into character RAM writes for the text
// renderer, handling control codes, screen clear and debug counters.
module ascii_text_writer
    import ascii_pkg::*;
#(
    parameter int unsigned COLS   = 80,
    parameter int unsigned ROWS   = 30,
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned CNT_W  = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        ascii_data,
    input  logic              ascii_valid,
    output logic              ascii_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [6:0]        cursor_col,
    output logic [4:0]        cursor_row,
    output logic [CNT_W-1:0]  char_count,
    output logic [CNT_W-1:0]  drop_count
);

    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(COLS * ROWS - 1);

    writer_state_t     state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic [CNT_W-1:0]  char_count_q, char_count_d;
    logic [CNT_W-1:0]  drop_count_q, drop_count_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    cursor_op_t        cur_op;
    logic [ADDR_W-1:0] cell_addr;
    logic              xfer;

    text_cursor #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_cursor (
        .clk     (clk),
        .reset_n (reset_n),
        .op      (cur_op),
        .col     (cursor_col),
        .row     (cursor_row)
    );

    assign ascii_ready = (state_q == IDLE);
    assign xfer        = ascii_valid && ascii_ready;
    assign cell_addr   = ADDR_W'(cursor_row) * ADDR_W'(COLS) + ADDR_W'(cursor_col);

    always_comb begin
        state_d      = state_q;
        clr_addr_d   = clr_addr_q;
        char_count_d = char_count_q;
        drop_count_d = drop_count_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        cur_op       = CUR_NONE;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    if (ascii_data >= PRINT_MIN && ascii_data <= PRINT_MAX) begin
                        wr_en_d      = 1'b1;
                        wr_addr_d    = cell_addr;
                        wr_data_d    = ascii_data;
                        char_count_d = char_count_q + 1'b1;
                        cur_op       = CUR_ADVANCE;
                    end else begin
                        case (ascii_data)
                            ASCII_LF: cur_op = CUR_NEWLINE;
                            ASCII_CR: cur_op = CUR_RETURN;
                            ASCII_BS: begin
                                // Erase lands on the cell left of the cursor, same row.
                                if (cursor_col != '0) begin
                                    wr_en_d   = 1'b1;
                                    wr_addr_d = cell_addr - 1'b1;
                                    wr_data_d = ASCII_SPACE;
                                    cur_op    = CUR_BACK;
                                end
                            end
                            ASCII_FF: begin
                                state_d    = CLEAR;
                                clr_addr_d = '0;
                            end
                            default: begin
                                if (drop_count_q != '1) begin
                                    drop_count_d = drop_count_q + 1'b1;
                                end
                            end
                        endcase
                    end
                end
            end
            CLEAR: begin
                wr_en_d    = 1'b1;
                wr_addr_d  = clr_addr_q;
                wr_data_d  = ASCII_SPACE;
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == LAST_CELL) begin
                    state_d = IDLE;
                    cur_op  = CUR_HOME;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            clr_addr_q   <= '0;
            char_count_q <= '0;
            drop_count_q <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            clr_addr_q   <= clr_addr_d;
            char_count_q <= char_count_d;
            drop_count_q <= drop_count_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign char_count = char_count_q;
    assign drop_count = drop_count_q;

endmodule
